alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the NIOSII datapath, replacing the combinational single-cycle ALU in the execute stage. Operands are accepted through a valid/ready handshake, and results with a full flag set (zero, negative, carry, overflow) are returned through a second valid/ready handshake. Single-cycle operations sustain one result per cycle. Multiply runs on an iterative shift-add unit, so the datapath no longer needs a WIDTH×WIDTH combinational multiplier. Opcodes 001–101 keep their existing meaning so the current control unit drives the block unchanged.

## Interface
- WIDTH, 32, operand/result width; legal range 4–64.
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous abort of the in-flight operation
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept an operation this cycle
- op  in  3  operation code
- a  in  WIDTH  operand A (register read port 1)
- b  in  WIDTH  operand B (output of the immediate mux)
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes the result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]
- carry  out  1  ADD: carry-out; SUB: borrow (a < b unsigned); 0 for all other ops
- ovf  out  1  signed overflow on ADD/SUB; 0 for all other ops

## Operation
- Opcodes:
  - 000 AND
  - 001 ADD
  - 010 SUB
  - 011 MUL (low WIDTH bits of the unsigned product)
  - 100 OR
  - 101 SLTU (unsigned compare; result is 1 or 0, zero-extended)
  - 110 XOR
  - 111 SLT (signed compare; result is 1 or 0, zero-extended)
- Accept condition: in_valid && in_ready. On accept, a, b and op are registered.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: MUL in progress. in_ready=0, out_valid=0. Bit counter counts 0..WIDTH-1.
  - DONE: out_valid=1. result and flags are held stable.
- Transitions:
  - IDLE → accept non-MUL → DONE.
  - IDLE → accept MUL → BUSY.
  - BUSY → counter == WIDTH-1 → DONE.
  - DONE with out_ready and no accept → IDLE.
  - DONE with out_ready and a simultaneous accept → DONE (non-MUL) or BUSY (MUL).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Flags are computed from the final result in the same cycle the result is registered.
- ADD/SUB carry and ovf are taken from a WIDTH+1-bit sum.
- flush takes priority over every handshake event: next state is IDLE, out_valid=0, and any accept in that cycle is ignored. result and flags keep their old values.
- reset has priority over flush.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, neg=0, carry=0, ovf=0, bit counter=0.

## Timing
- Non-MUL latency: accept at edge k → out_valid high from edge k+1.
- Non-MUL throughput: one operation per cycle while out_ready is held high.
- MUL latency: accept at edge k → out_valid high from edge k+WIDTH.
- MUL throughput: one operation per WIDTH+1 cycles when back-to-back.
- Backpressure: while out_valid && !out_ready, result and flags must not change and in_ready=0.
- in_valid may drop without being accepted; no state change results.
- Reset asserted mid-MUL: the block is in IDLE the cycle after, with no residual output.
- out_valid is never combinationally dependent on in_valid.
- in_ready depends combinationally on out_ready only.

## Structure
- Package alu_pkg holds:
  - op enum: OP_AND, OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_SLTU, OP_XOR, OP_SLT;
  - state enum: IDLE, BUSY, DONE;
  - a flags struct: zero, neg, carry, ovf.
- Sub-module alu_seq_mul (parametrised on WIDTH):
  - inputs: start, a, b, flush/reset;
  - outputs: done pulse and product low word;
  - contents: shift-add accumulator, multiplicand shifter, bit counter.
- Top level holds the FSM, the single-cycle operation datapath, the output registers and the flag logic. Target is roughly 200–300 lines in total.

## Test plan
- WIDTH=32: ADD a=0xFFFFFFFF, b=1 → result=0, zero=1, carry=1, ovf=0. Then ADD 0x7FFFFFFF+1 → result=0x80000000, neg=1, ovf=1, carry=0.
- WIDTH=32: SUB 3−5 → result=0xFFFFFFFE, carry=1, neg=1. SLTU 3,5 → result=1. SLT 0xFFFFFFFF,1 → result=1. SLTU 0xFFFFFFFF,1 → result=0.
- WIDTH=8: MUL 13×11 → out_valid exactly 8 cycles after accept, result=0x8F. MUL 0xFF×0xFF → result=0x01.
- Back-to-back ADD, XOR, AND with out_ready=1 → three results on three consecutive cycles and in_ready held at 1. Then drop out_ready for 4 cycles → result stable and in_ready=0 throughout.
- flush pulsed 3 cycles into a MUL → out_valid never rises, IDLE next cycle, the following ADD 2+2 returns 4 at normal latency.
- reset asserted during DONE with out_ready=0 → next cycle out_valid=0, result=0, all flags 0, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM encodings and the flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_OR   = 3'b100,
        OP_SLTU = 3'b101,
        OP_XOR  = 3'b110,
        OP_SLT  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low product word only.
module alu_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    // The last step is folded into the output so the product is ready with the done pulse.
    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign product_o = acc_d;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the execute stage: single-cycle logic/arith ops plus iterative MUL,
// with valid/ready handshakes on both the operand and the result side.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output state_e           dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never waits
    // on ready, and once out_valid is high the result and flags hold until it is taken.
    state_e           state_q, state_d;
    op_e              op_in;
    logic             accept;
    logic             mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH:0]   sum_w, diff_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_ovf;
    logic             load_alu, load_mul;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;

    assign op_in     = op_e'(op);
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && !flush && (op_in == OP_MUL);
    assign dbg_state = state_q;

    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op_in)
            OP_AND:  alu_res = a & b;
            OP_ADD: begin
                alu_res   = sum_w[WIDTH-1:0];
                alu_carry = sum_w[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff_w[WIDTH-1:0];
                alu_carry = diff_w[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:   alu_res = a | b;
            // The borrow of a-b is exactly the unsigned a < b
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, diff_w[WIDTH]};
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = '0;
        endcase
    end

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i     (clk),
        .reset_i   (reset),
        .flush_i   (flush),
        .start_i   (mul_start),
        .a_i       (a),
        .b_i       (b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (op_in == OP_MUL) ? BUSY : DONE;
            BUSY: if (mul_done) state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    if (accept) state_d = (op_in == OP_MUL) ? BUSY : DONE;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    assign load_alu = accept && !flush && (op_in != OP_MUL);
    assign load_mul = (state_q == BUSY) && mul_done && !flush;

    always_comb begin
        result_d      = load_mul ? mul_product : alu_res;
        flags_d.zero  = (result_d == '0);
        flags_d.neg   = result_d[WIDTH-1];
        flags_d.carry = load_mul ? 1'b0 : alu_carry;
        flags_d.ovf   = load_mul ? 1'b0 : alu_ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_alu || load_mul) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign result = result_q;
    assign zero   = flags_q.zero;
    assign neg    = flags_q.neg;
    assign carry  = flags_q.carry;
    assign ovf    = flags_q.ovf;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases on 32- and 8-bit instances plus a
// randomized run scored against a plain-arithmetic model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int W8 = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- 32-bit instance ----------------
    logic         flush, in_valid, in_ready, out_valid, out_ready;
    logic         zero, neg, carry, ovf;
    logic [2:0]   op;
    logic [W-1:0] a, b, result;
    state_e       dbg_state;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .dbg_state(dbg_state)
    );

    // ---------------- 8-bit instance ----------------
    logic          flush8, in_valid8, in_ready8, out_valid8, out_ready8;
    logic          zero8, neg8, carry8, ovf8;
    logic [2:0]    op8;
    logic [W8-1:0] a8, b8, result8;
    state_e        dbg_state8;

    alu_mc #(.WIDTH(W8)) dut8 (
        .clk(clk), .reset(reset), .flush(flush8),
        .in_valid(in_valid8), .in_ready(in_ready8), .op(op8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .zero(zero8), .neg(neg8), .carry(carry8), .ovf(ovf8), .dbg_state(dbg_state8)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {zero, neg, carry, ovf, result[63:0]} for a w-bit ALU.
    function automatic logic [67:0] model(input logic [2:0] o, input logic [63:0] x,
                                          input logic [63:0] y, input int w);
        logic [63:0] m, ux, uy, r;
        longint      sx, sy, s, smax, smin;
        logic        c, v;
        m    = (64'd1 << w) - 64'd1;
        ux   = x & m;
        uy   = y & m;
        smax = (longint'(1) <<< (w - 1)) - 1;
        smin = -(longint'(1) <<< (w - 1));
        sx   = ux[w-1] ? longint'(ux) - longint'(m) - 1 : longint'(ux);
        sy   = uy[w-1] ? longint'(uy) - longint'(m) - 1 : longint'(uy);
        r = '0; c = 1'b0; v = 1'b0; s = 0;
        case (o)
            3'd0: r = ux & uy;
            3'd1: begin r = (ux + uy) & m; c = (ux + uy) > m; s = sx + sy; v = (s > smax) || (s < smin); end
            3'd2: begin r = (ux - uy) & m; c = ux < uy;       s = sx - sy; v = (s > smax) || (s < smin); end
            3'd3: r = (ux * uy) & m;
            3'd4: r = ux | uy;
            3'd5: r = (ux < uy) ? 64'd1 : 64'd0;
            3'd6: r = ux ^ uy;
            default: r = (sx < sy) ? 64'd1 : 64'd0;
        endcase
        return {(r == 64'd0), (((r >> (w - 1)) & 64'd1) != 64'd0), c, v, r};
    endfunction

    // ---------------- scoreboard / protocol monitor (32-bit) ----------------
    logic [W+3:0] exp_q[$];
    logic [W+3:0] cur_obs, prev_obs, exp_v;
    logic [67:0]  mres;
    logic         prev_valid = 1'b0, prev_ready = 1'b0, prev_flush = 1'b0, prev_reset = 1'b1;

    always @(negedge clk) begin
        cur_obs = {zero, neg, carry, ovf, result};
        if (!reset && prev_valid && !prev_ready && !prev_flush && !prev_reset) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_hold", 64'(cur_obs), 64'(prev_obs));
        end
        if (out_valid && !out_ready) check("bp_in_ready", 64'(in_ready), 64'd0);
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    check("sb_result", 64'(result), 64'(exp_v[W-1:0]));
                    check("sb_flags", 64'({zero, neg, carry, ovf}), 64'(exp_v[W+3:W]));
                end
            end
            if (in_valid && in_ready) begin
                mres = model(op, 64'(a), 64'(b), W);
                exp_q.push_back({mres[67:64], mres[W-1:0]});
            end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_flush = flush;
        prev_reset = reset;
        prev_obs   = cur_obs;
    end

    // ---------------- driver tasks ----------------
    task automatic op32(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er, input logic [3:0] ef);
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_result"}, 64'(result), 64'(er));
        check({tag, "_flags"}, 64'({zero, neg, carry, ovf}), 64'(ef));
    endtask

    task automatic mul8(input string tag, input logic [W8-1:0] x, input logic [W8-1:0] y,
                        input logic [W8-1:0] er);
        int          n;
        logic [67:0] mr;
        mr = model(3'd3, 64'(x), 64'(y), W8);
        @(posedge clk); #1;
        in_valid8 = 1'b1; op8 = 3'd3; a8 = x; b8 = y; out_ready8 = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready8), 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid8 && n < 40);
        check({tag, "_latency"}, 64'(n - 1), 64'(W8));
        check({tag, "_result"}, 64'(result8), 64'(er));
        check({tag, "_flags"}, 64'({zero8, neg8, carry8, ovf8}), 64'(mr[67:64]));
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    int   n, vis;
    logic [2:0] rop;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({zero, neg, carry, ovf}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Arithmetic and compare corners
        op32("add_wrap", 3'd1, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1010);
        op32("add_ovf", 3'd1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0101);
        op32("sub_borrow", 3'd2, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0110);
        op32("sltu_lt", 3'd5, 32'd3, 32'd5, 32'd1, 4'b0000);
        op32("slt_neg", 3'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000);
        op32("sltu_ge", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1000);
        @(posedge clk); #1;

        // Back-to-back ADD, XOR, AND, then backpressure
        in_valid = 1'b1; out_ready = 1'b1; op = 3'd1; a = 32'd5; b = 32'd7;
        @(negedge clk);
        check("b2b_rdy0", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        op = 3'd6; a = 32'hF0F0; b = 32'hFF00;
        @(negedge clk);
        check("b2b_v1", 64'(out_valid), 64'd1);
        check("b2b_add", 64'(result), 64'd12);
        check("b2b_rdy1", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        op = 3'd0;
        @(negedge clk);
        check("b2b_v2", 64'(out_valid), 64'd1);
        check("b2b_xor", 64'(result), 64'h0FF0);
        check("b2b_rdy2", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_and", 64'(result), 64'hF000);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Flush three cycles into a MUL
        in_valid = 1'b1; op = 3'd3; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_state", 64'(dbg_state), 64'(IDLE));
        check("flush_in_ready", 64'(in_ready), 64'd1);
        vis = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (out_valid) vis++;
            @(negedge clk);
        end
        check("flush_no_valid", 64'(vis), 64'd0);
        op32("post_flush_add", 3'd1, 32'd2, 32'd2, 32'd4, 4'b0000);
        @(posedge clk); #1;

        // Reset asserted mid-MUL
        in_valid = 1'b1; op = 3'd3; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstmul_state", 64'(dbg_state), 64'(IDLE));
        vis = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (out_valid) vis++;
            @(negedge clk);
        end
        check("rstmul_no_valid", 64'(vis), 64'd0);

        // Reset while holding a result in DONE
        @(posedge clk); #1;
        in_valid = 1'b1; op = 3'd1; a = 32'h7FFF_FFFF; b = 32'h1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rstdone_pre_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstdone_valid", 64'(out_valid), 64'd0);
        check("rstdone_result", 64'(result), 64'd0);
        check("rstdone_flags", 64'({zero, neg, carry, ovf}), 64'd0);
        check("rstdone_in_ready", 64'(in_ready), 64'd1);

        // 8-bit multiplier: latency, wrap, throughput
        mul8("mul8_13x11", 8'd13, 8'd11, 8'h8F);
        mul8("mul8_ffxff", 8'hFF, 8'hFF, 8'h01);
        for (int i = 0; i < 4; i++) begin
            logic [W8-1:0] x, y;
            logic [67:0]   mr;
            x = W8'($urandom); y = W8'($urandom);
            mr = model(3'd3, 64'(x), 64'(y), W8);
            mul8("mul8_rand", x, y, mr[W8-1:0]);
        end
        in_valid8 = 1'b1; op8 = 3'd3; a8 = 8'd2; b8 = 8'd3; out_ready8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'd5; b8 = 8'd7;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready8 && n < 40);
        check("mul8_tput", 64'(n), 64'(W8 + 1));
        check("mul8_tput_r1", 64'(result8), 64'd6);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid8 && n < 40);
        check("mul8_tput_r2", 64'(result8), 64'd35);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'd3 && $urandom_range(0, 2) != 0) rop = 3'd1;
            in_valid = 1'b1; op = rop; a = rnd_operand(); b = rnd_operand();
            out_ready = ($urandom_range(0, 3) != 0);
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 100) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                n++;
            end
            if (n >= 100) check("rand_accept_timeout", 64'(n), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
